// File: rtl/nar_pkg.sv
// nar_pkg
// Shared constants and types for the NAR-Net neuron datapath.
//   N, Q        : default data width and fractional bits (Q1.Q signed fixed point)
//   NUM_IN      : inputs (and weights) per neuron
//   IDX_W       : width of the weight/input index
//   SAT_MAX/MIN : saturation limits of an N-bit signed value
//   seqState_t  : sequencer states
package nar_pkg;

  localparam int N      = 10;
  localparam int Q      = 9;
  localparam int NUM_IN = 4;
  localparam int IDX_W  = 2;

  localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } seqState_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if
// Bundles the sequencer's control, activation-stream, weight-write and
// accumulator-side signals.
//   start, x_valid, x_data, w_we, w_addr, w_data : driven by the master
//   x_ready, acc_a, acc_add, acc_clr, busy, done : driven by the sequencer (slave)
interface mac_sequencer_if
  import nar_pkg::*;
#(
  parameter int DATA_W = N,
  parameter int ADDR_W = IDX_W
);

  logic                     start;
  logic                     x_valid;
  logic signed [DATA_W-1:0] x_data;
  logic                     x_ready;
  logic                     w_we;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic signed [DATA_W-1:0] acc_a;
  logic                     acc_add;
  logic                     acc_clr;
  logic                     busy;
  logic                     done;

  modport master (
    output start, x_valid, x_data, w_we, w_addr, w_data,
    input  x_ready, acc_a, acc_add, acc_clr, busy, done
  );

  modport slave (
    input  start, x_valid, x_data, w_we, w_addr, w_data,
    output x_ready, acc_a, acc_add, acc_clr, busy, done
  );

endinterface

// File: rtl/fxp_mul_sat.sv
// fxp_mul_sat
// Combinational signed fixed-point multiply: full 2W-bit product, arithmetic
// shift right by FRAC (floor), then saturate to the W-bit signed range.
//   i_a, i_b : W-bit signed operands
//   o_y      : W-bit signed saturated result
module fxp_mul_sat
  import nar_pkg::*;
#(
  parameter int W    = N,
  parameter int FRAC = Q
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_y
);

  // Saturation limits widened to the product width so the compare is signed.
  localparam logic signed [2*W-1:0] LIM_HI = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] LIM_LO = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W-1:0] w_product;
  logic signed [2*W-1:0] w_shifted;

  assign w_product = i_a * i_b;
  assign w_shifted = w_product >>> FRAC;

  always_comb begin
    o_y = w_shifted[W-1:0];
    if (w_shifted > LIM_HI) begin
      o_y = LIM_HI[W-1:0];
    end else if (w_shifted < LIM_LO) begin
      o_y = LIM_LO[W-1:0];
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer
// Feeds a fixed-point accumulator with weight*activation products for one
// neuron. Weights live in a small register file written while idle; a run
// clears the accumulator, accepts NUM_INPUTS activations over valid/ready,
// issues one registered add per accepted activation and pulses done when the
// accumulator output holds the complete dot product.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mac_sequencer_if slave (start, activation stream, weight
//              writes, accumulator operand/add/clear, busy, done)
module mac_sequencer
  import nar_pkg::*;
#(
  parameter int DATA_W     = N,
  parameter int FRAC_W     = Q,
  parameter int NUM_INPUTS = NUM_IN,
  parameter int IDX_WIDTH  = IDX_W
) (
  input logic            clk,
  input logic            rst,
  mac_sequencer_if.slave bus
);

  seqState_t                r_state;
  seqState_t                w_stateNext;
  logic [IDX_WIDTH-1:0]     r_idx;
  logic signed [DATA_W-1:0] r_weights [NUM_INPUTS];
  logic signed [DATA_W-1:0] r_accA;
  logic                     r_accAdd;

  logic                     w_handshake;
  logic                     w_lastIdx;
  logic                     w_addrOk;
  logic signed [DATA_W-1:0] w_product;

  assign w_handshake = bus.x_valid && (r_state == RUN);
  assign w_lastIdx   = (r_idx == IDX_WIDTH'(NUM_INPUTS - 1));

  // Every address is legal when NUM_INPUTS fills the index space; otherwise
  // writes to the unused top addresses are dropped.
  generate
    if (NUM_INPUTS == (1 << IDX_WIDTH)) begin : g_fullAddr
      assign w_addrOk = 1'b1;
    end else begin : g_partAddr
      assign w_addrOk = ({{(32-IDX_WIDTH){1'b0}}, bus.w_addr} < 32'(NUM_INPUTS));
    end
  endgenerate

  fxp_mul_sat #(
    .W    (DATA_W),
    .FRAC (FRAC_W)
  ) u_mul (
    .i_a (bus.x_data),
    .i_b (r_weights[r_idx]),
    .o_y (w_product)
  );

  // Next-state logic: CLEAR, DRAIN and DONE each last exactly one cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_stateNext = CLEAR;
      CLEAR:   w_stateNext = RUN;
      RUN:     if (w_handshake && w_lastIdx) w_stateNext = DRAIN;
      DRAIN:   w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // State, index, weight file and the registered accumulator operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_accA   <= '0;
      r_accAdd <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_weights[i] <= '0;
      end
    end else begin
      r_state  <= w_stateNext;
      r_accAdd <= w_handshake;
      if (w_handshake) begin
        r_accA <= w_product;
        r_idx  <= w_lastIdx ? '0 : r_idx + 1'b1;
      end
      if (r_state == CLEAR) begin
        r_idx <= '0;
      end
      // A write in the same cycle as start lands before the first product.
      if ((r_state == IDLE) && bus.w_we && w_addrOk) begin
        r_weights[bus.w_addr] <= bus.w_data;
      end
    end
  end

  assign bus.x_ready = (r_state == RUN);
  assign bus.acc_clr = (r_state == CLEAR);
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == DONE);
  assign bus.acc_a   = r_accA;
  assign bus.acc_add = r_accAdd;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer
// Self-checking bench for mac_sequencer. A behavioural model holds the weight
// vector and computes each expected product with plain integer arithmetic;
// scenario tasks drive the DUT on the falling edge and check its outputs there.
module tb_mac_sequencer;
  import nar_pkg::*;

  typedef logic signed [N-1:0] sample_t;
  typedef sample_t vec_t [NUM_IN];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mac_sequencer_if bus ();

  mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  int wModel [NUM_IN];

  // Reference product: exact integer product, floor division by 2^Q, clamp.
  function automatic sample_t refMulSat(input int x, input int w);
    int p;
    int s;
    int scale;
    scale = 1 << Q;
    p = x * w;
    if (p >= 0) s = p / scale;
    else        s = -((-p + scale - 1) / scale);
    if (s > (1 << (N-1)) - 1) s = (1 << (N-1)) - 1;
    if (s < -(1 << (N-1)))    s = -(1 << (N-1));
    return sample_t'(s);
  endfunction

  task automatic applyStimulus();
    bus.start   = 1'b0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.w_we    = 1'b0;
    bus.w_addr  = '0;
    bus.w_data  = '0;
  endtask

  // Writes one weight while the DUT is idle and mirrors it into the model.
  task automatic writeWeight(input int addr, input int data);
    @(negedge clk);
    bus.w_we   = 1'b1;
    bus.w_addr = IDX_W'(addr);
    bus.w_data = sample_t'(data);
    wModel[addr] = data;
    @(negedge clk);
    bus.w_we = 1'b0;
  endtask

  task automatic loadRandomWeights();
    for (int i = 0; i < NUM_IN; i++) writeWeight(i, int'($urandom_range(0, 1023)) - 512);
  endtask

  // One complete dot product, checked cycle by cycle.
  //   patBits/patLen : explicit x_valid pattern for the first RUN cycles
  //   randomGaps     : after the pattern, insert random idle cycles
  //   pokeInRun      : drive start and a weight write while busy (must be ignored)
  //   writeAtStart   : write weight wAddrS=wDatS in the start cycle
  //   abortAfter     : assert rst once that many handshakes have happened (-1: never)
  task automatic runDot(input string tag, input vec_t xs, input logic [15:0] patBits,
                        input int patLen, input bit randomGaps, input bit pokeInRun,
                        input bit writeAtStart, input int wAddrS, input int wDatS,
                        input int abortAfter);
    int      k;
    int      cyc;
    bit      expAdd;
    bit      v;
    sample_t expA;
    k = 0; cyc = 0; expAdd = 1'b0; expA = '0;

    @(negedge clk);
    bus.start = 1'b1;
    if (writeAtStart) begin
      bus.w_we   = 1'b1;
      bus.w_addr = IDX_W'(wAddrS);
      bus.w_data = sample_t'(wDatS);
      wModel[wAddrS] = wDatS;
    end

    @(negedge clk);
    bus.start = 1'b0;
    bus.w_we  = 1'b0;
    compared++; if (bus.acc_clr !== 1'b1) begin mismatched++; $display("[TB] FAIL %s clear: acc_clr=%b expected 1", tag, bus.acc_clr); end
    compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL %s clear_busy: busy=%b expected 1", tag, bus.busy); end
    compared++; if (bus.x_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL %s clear_ready: x_ready=%b expected 0", tag, bus.x_ready); end
    compared++; if (bus.acc_add !== 1'b0) begin mismatched++; $display("[TB] FAIL %s clear_add: acc_add=%b expected 0", tag, bus.acc_add); end
    bus.x_valid = 1'($urandom_range(0, 1));
    bus.x_data  = sample_t'($urandom);

    while (k < NUM_IN && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (abortAfter == k) begin
        rst = 1'b1;
        applyStimulus();
        @(negedge clk);
        rst = 1'b0;
        compared++; if (bus.acc_a !== '0 || bus.acc_add !== 1'b0 || bus.acc_clr !== 1'b0)
          begin mismatched++; $display("[TB] FAIL %s abort_acc: acc_a=%0d add=%b clr=%b expected 0/0/0", tag, bus.acc_a, bus.acc_add, bus.acc_clr); end
        compared++; if (bus.x_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
          begin mismatched++; $display("[TB] FAIL %s abort_ctl: ready=%b busy=%b done=%b expected 0/0/0", tag, bus.x_ready, bus.busy, bus.done); end
        for (int i = 0; i < NUM_IN; i++) wModel[i] = 0;
        return;
      end
      compared++; if (bus.x_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL %s run_ready: x_ready=%b expected 1", tag, bus.x_ready); end
      compared++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.acc_clr !== 1'b0)
        begin mismatched++; $display("[TB] FAIL %s run_ctl: busy=%b done=%b clr=%b expected 1/0/0", tag, bus.busy, bus.done, bus.acc_clr); end
      compared++; if (bus.acc_add !== expAdd) begin mismatched++; $display("[TB] FAIL %s run_add k=%0d: acc_add=%b expected %b", tag, k, bus.acc_add, expAdd); end
      if (expAdd) begin
        compared++; if (bus.acc_a !== expA) begin mismatched++; $display("[TB] FAIL %s run_acc_a k=%0d: acc_a=%0d expected %0d", tag, k, bus.acc_a, expA); end
      end
      if (cyc - 1 < patLen) v = patBits[cyc - 1];
      else if (randomGaps)  v = ($urandom_range(0, 2) != 0);
      else                  v = 1'b1;
      if (pokeInRun) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.w_we   = 1'b1;
        bus.w_addr = '0;
        bus.w_data = sample_t'(100);
      end
      bus.x_valid = v;
      bus.x_data  = v ? xs[k] : sample_t'($urandom);
      if (v) begin
        expAdd = 1'b1;
        expA   = refMulSat(int'(xs[k]), wModel[k]);
        k++;
      end else begin
        expAdd = 1'b0;
      end
    end

    if (k < NUM_IN) begin
      compared++; mismatched++;
      $display("[TB] FAIL %s timeout: handshakes=%0d expected %0d", tag, k, NUM_IN);
      applyStimulus();
      return;
    end

    // DRAIN: the last add is visible, the stream is closed.
    @(negedge clk);
    compared++; if (bus.acc_add !== 1'b1) begin mismatched++; $display("[TB] FAIL %s drain_add: acc_add=%b expected 1", tag, bus.acc_add); end
    compared++; if (bus.acc_a !== expA) begin mismatched++; $display("[TB] FAIL %s drain_acc_a: acc_a=%0d expected %0d", tag, bus.acc_a, expA); end
    compared++; if (bus.x_ready !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1)
      begin mismatched++; $display("[TB] FAIL %s drain_ctl: ready=%b done=%b busy=%b expected 0/0/1", tag, bus.x_ready, bus.done, bus.busy); end
    bus.x_valid = 1'b1;
    bus.x_data  = sample_t'($urandom);

    // DONE: two cycles after the last handshake.
    @(negedge clk);
    compared++; if (bus.done !== 1'b1) begin mismatched++; $display("[TB] FAIL %s done: done=%b expected 1", tag, bus.done); end
    compared++; if (bus.acc_add !== 1'b0 || bus.x_ready !== 1'b0)
      begin mismatched++; $display("[TB] FAIL %s done_add: add=%b ready=%b expected 0/0", tag, bus.acc_add, bus.x_ready); end
    applyStimulus();

    @(negedge clk);
    compared++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.acc_add !== 1'b0)
      begin mismatched++; $display("[TB] FAIL %s idle: busy=%b done=%b add=%b expected 0/0/0", tag, bus.busy, bus.done, bus.acc_add); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus();
    repeat (2) @(negedge clk);
    compared++; if (bus.acc_a !== '0) begin mismatched++; $display("[TB] FAIL reset_acc_a: acc_a=%0d expected 0", bus.acc_a); end
    compared++; if (bus.acc_add !== 1'b0 || bus.acc_clr !== 1'b0)
      begin mismatched++; $display("[TB] FAIL reset_acc: add=%b clr=%b expected 0/0", bus.acc_add, bus.acc_clr); end
    compared++; if (bus.x_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin mismatched++; $display("[TB] FAIL reset_ctl: ready=%b busy=%b done=%b expected 0/0/0", bus.x_ready, bus.busy, bus.done); end
    rst = 1'b0;
    for (int i = 0; i < NUM_IN; i++) wModel[i] = 0;
  endtask

  task automatic test_half_weights();
    vec_t xs;
    for (int i = 0; i < NUM_IN; i++) begin writeWeight(i, 256); xs[i] = sample_t'(256); end
    runDot("half", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_saturation();
    vec_t xs;
    loadRandomWeights();
    for (int i = 0; i < NUM_IN; i++) xs[i] = sample_t'($urandom);
    xs[0] = sample_t'(-512);
    writeWeight(0, -512);
    runDot("sat_pos", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    writeWeight(0, 511);
    runDot("sat_neg", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_floor();
    vec_t xs;
    loadRandomWeights();
    for (int i = 0; i < NUM_IN; i++) xs[i] = sample_t'($urandom);
    writeWeight(1, 256);
    xs[1] = sample_t'(-1);
    runDot("floor_neg", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    xs[1] = sample_t'(1);
    runDot("floor_pos", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_gaps();
    vec_t xs;
    loadRandomWeights();
    for (int i = 0; i < NUM_IN; i++) xs[i] = sample_t'($urandom);
    // x_valid sequence 1,0,0,1,1,0,1 read from bit 0 upward.
    runDot("gaps", xs, 16'b1011001, 7, 1'b0, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_start_with_write();
    vec_t xs;
    loadRandomWeights();
    for (int i = 0; i < NUM_IN; i++) xs[i] = sample_t'($urandom);
    runDot("start_write", xs, 16'h0, 0, 1'b0, 1'b0, 1'b1, 0, int'($urandom_range(0, 1023)) - 512, -1);
  endtask

  task automatic test_reset_midrun();
    vec_t xs;
    loadRandomWeights();
    for (int i = 0; i < NUM_IN; i++) xs[i] = sample_t'($urandom);
    runDot("abort", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 2);
    // Weights were cleared by the reset, so every product is zero.
    runDot("after_abort_zero", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    loadRandomWeights();
    runDot("after_abort_reload", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_busy_ignore();
    vec_t xs;
    loadRandomWeights();
    writeWeight(0, -300);
    for (int i = 0; i < NUM_IN; i++) xs[i] = sample_t'($urandom);
    xs[0] = sample_t'(400);
    runDot("busy_poke", xs, 16'h0, 0, 1'b1, 1'b1, 1'b0, 0, 0, -1);
    runDot("busy_rerun", xs, 16'h0, 0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
  endtask

  task automatic test_back_to_back_random();
    vec_t xs;
    for (int r = 0; r < 8; r++) begin
      loadRandomWeights();
      for (int i = 0; i < NUM_IN; i++) xs[i] = sample_t'($urandom);
      runDot("random", xs, 16'h0, 0, 1'(r % 2), 1'b0, 1'b0, 0, 0, -1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    applyStimulus();
    test_reset();
    test_half_weights();
    test_saturation();
    test_floor();
    test_gaps();
    test_start_with_write();
    test_reset_midrun();
    test_busy_ignore();
    test_back_to_back_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
